// File: rtl/mem_arbiter.sv
// Shared unified-memory arbiter between the I-cache and D-cache miss controllers.
// Define ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
//
// state   | meaning
// S_IDLE  | no operation; arbitrate and grant in the same cycle
// S_FILL  | line fill: issue WORDS reads, route WORDS returns to the owner
// S_WRITE | single-word D-side write-through, completes in one cycle
module mem_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     i_grant,
  output logic [DATA_W-1:0]        i_data,
  output logic                     i_valid,
  output logic [$clog2(WORDS)-1:0] i_word,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_grant,
  output logic [DATA_W-1:0]        d_data,
  output logic                     d_valid,
  output logic [$clog2(WORDS)-1:0] d_word,
  output logic                     d_done,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid,
  output logic                     busy
);

  localparam int WI = $clog2(WORDS);
  localparam int CW = WI + 1;
  localparam int LB = WI + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic              owner_d_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_wdata_q;
  logic [CW-1:0]     issue_q;
  logic [CW-1:0]     ret_q;
  logic              pick_d, grant_i, grant_d;
  logic              idle, issuing, ret_fire, fill_done, wr_cyc;
  logic [ADDR_W-1:0] line_base;

`ifdef ARB_RR_EN
  logic last_d_q;
`endif

  always_comb begin
    idle = (state_q == S_IDLE) && !rst;
`ifdef ARB_RR_EN
    // on a tie the side not granted last time wins
    pick_d = d_req && (!i_req || !last_d_q);
`else
    pick_d = d_req;
`endif
    grant_d   = idle && pick_d;
    grant_i   = idle && i_req && !pick_d;
    issuing   = (state_q == S_FILL) && (issue_q < CNT_FULL) && !rst;
    ret_fire  = (state_q == S_FILL) && mem_rvalid && !rst;
    fill_done = ret_fire && (ret_q == CNT_LAST);
    wr_cyc    = (state_q == S_WRITE) && !rst;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d)      state_d = d_we ? S_WRITE : S_FILL;
        else if (grant_i) state_d = S_FILL;
      end
      S_FILL:  if (fill_done) state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_d_q   <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      issue_q     <= '0;
      ret_q       <= '0;
`ifdef ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        owner_d_q   <= 1'b1;
        cap_addr_q  <= d_addr;
        cap_wdata_q <= d_wdata;
        issue_q     <= '0;
        ret_q       <= '0;
      end else if (grant_i) begin
        owner_d_q  <= 1'b0;
        cap_addr_q <= i_addr;
        issue_q    <= '0;
        ret_q      <= '0;
      end
      if (issuing)  issue_q <= issue_q + 1'b1;
      if (ret_fire) ret_q   <= ret_q + 1'b1;
`ifdef ARB_RR_EN
      if (grant_d)      last_d_q <= 1'b1;
      else if (grant_i) last_d_q <= 1'b0;
`endif
    end
  end

  // data/address outputs are held at zero whenever they are not qualified
  always_comb begin
    line_base = {cap_addr_q[ADDR_W-1:LB], {LB{1'b0}}};
    i_grant   = grant_i;
    d_grant   = grant_d;
    mem_en    = issuing || wr_cyc;
    mem_wr    = wr_cyc;
    mem_addr  = '0;
    if (issuing)     mem_addr = line_base + ADDR_W'({issue_q[WI-1:0], 1'b0});
    else if (wr_cyc) mem_addr = cap_addr_q;
    mem_wdata = wr_cyc ? cap_wdata_q : '0;
    i_valid   = ret_fire && !owner_d_q;
    d_valid   = ret_fire && owner_d_q;
    i_data    = i_valid ? mem_rdata : '0;
    d_data    = d_valid ? mem_rdata : '0;
    i_word    = i_valid ? ret_q[WI-1:0] : '0;
    d_word    = d_valid ? ret_q[WI-1:0] : '0;
    i_done    = i_valid && (ret_q == CNT_LAST);
    d_done    = (d_valid && (ret_q == CNT_LAST)) || wr_cyc;
    busy      = (state_q != S_IDLE) && !rst;
  end

endmodule
